// File: rtl/fc_pkg.sv
// Shared types and constants for the fully-connected layer datapath:
// sequencer state encoding, default geometry and width helpers.
package fc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } fc_state_e;

    localparam int DEF_INNEURON  = 64;
    localparam int DEF_OUTNEURON = 16;
    localparam int DEF_PO        = 4;
    localparam int DEF_RD_LAT    = 2;
    localparam int DEF_IN_AW     = 6;
    localparam int DEF_W_AW      = 8;
    localparam int DEF_OUT_AW    = 4;

    localparam int DEF_NBEAT = DEF_INNEURON / 2;
    localparam int DEF_NGRP  = DEF_OUTNEURON / DEF_PO;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // Counter width that stays at least one bit for single-value ranges.
    function automatic int cnt_width(input int count);
        return (count <= 1) ? 1 : clog2(count);
    endfunction

    function automatic int nbeat(input int inneuron);
        return inneuron / 2;
    endfunction

    function automatic int ngrp(input int outneuron, input int po);
        return outneuron / po;
    endfunction

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// Scheduler, memory and MAC control bundle driven by the layer sequencer.
interface fc_layer_sequencer_if #(
    parameter int IAW = fc_pkg::DEF_IN_AW,
    parameter int WAW = fc_pkg::DEF_W_AW,
    parameter int OAW = fc_pkg::DEF_OUT_AW
);
    // start is a one-cycle request honoured only while busy is low; there is no
    // back-pressure: reads, MAC strobes and the result write are fixed-latency
    // fire-and-forget pulses that the slaves must accept in the cycle shown.
    logic           start;
    logic           busy;
    logic           done;
    logic           in_neuron_rden;
    logic [IAW-1:0] in_neuron_addr_a;
    logic [IAW-1:0] in_neuron_addr_b;
    logic           fc_weight_rden;
    logic [WAW-1:0] fc_weight_addr;
    logic           accum_sload;
    logic           enable_mult;
    logic           out_wren;
    logic [OAW-1:0] out_addr;

    modport master (
        input  start,
        output busy, done,
        output in_neuron_rden, in_neuron_addr_a, in_neuron_addr_b,
        output fc_weight_rden, fc_weight_addr,
        output accum_sload, enable_mult,
        output out_wren, out_addr
    );

    modport slave (
        output start,
        input  busy, done,
        input  in_neuron_rden, in_neuron_addr_a, in_neuron_addr_b,
        input  fc_weight_rden, fc_weight_addr,
        input  accum_sload, enable_mult,
        input  out_wren, out_addr
    );
endinterface

// File: rtl/fc_valid_delay.sv
// Fixed-depth (valid, first) tag pipe matching memory + multiplier latency;
// freeze holds every stage in place.
module fc_valid_delay #(
    parameter int DEPTH = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic freeze,
    input  logic in_valid,
    input  logic in_first,
    output logic out_valid,
    output logic out_first
);
    logic [DEPTH-1:0][1:0] sr;

    always_ff @(posedge clock) begin
        if (reset) begin
            sr <= '0;
        end else if (!freeze) begin
            sr[0] <= {in_valid, in_first};
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign out_valid = sr[DEPTH-1][1];
    assign out_first = sr[DEPTH-1][0];
endmodule

// File: rtl/fc_layer_sequencer.sv
// One fully-connected layer pass: per output group, issue paired input/weight
// reads, time the accumulator strobes, write PO results. FC_HOLD_EN adds a stall input.
module fc_layer_sequencer
    import fc_pkg::*;
#(
    parameter int INNEURON                = DEF_INNEURON,
    parameter int OUTNEURON               = DEF_OUTNEURON,
    parameter int PO                      = DEF_PO,
    parameter int RD_LAT                  = DEF_RD_LAT,
    parameter int FC_INNEURON_ADDR_WIDTH  = DEF_IN_AW,
    parameter int FC_WEIGHT_ADDR_WIDTH    = DEF_W_AW,
    parameter int FC_OUTNEURON_ADDR_WIDTH = DEF_OUT_AW
) (
    input  logic                        clock,
    input  logic                        reset,
`ifdef FC_HOLD_EN
    input  logic                        hold,
`endif
    fc_layer_sequencer_if.master        bus,
    output fc_state_e                   state_dbg
);
    localparam int NBEAT = nbeat(INNEURON);
    localparam int NGRP  = ngrp(OUTNEURON, PO);
    localparam int KW    = cnt_width(NBEAT);
    localparam int GW    = cnt_width(NGRP);
    localparam int DW    = cnt_width(RD_LAT);

    localparam logic [KW-1:0] K_LAST = KW'(NBEAT - 1);
    localparam logic [GW-1:0] G_LAST = GW'(NGRP - 1);
    localparam logic [DW-1:0] D_LAST = DW'(RD_LAT - 1);

    if (INNEURON < 2 || (INNEURON % 2) != 0) begin : g_err_inneuron
        $error("INNEURON must be even and at least 2");
    end
    if (PO < 1 || (OUTNEURON % PO) != 0 || OUTNEURON < PO) begin : g_err_outneuron
        $error("OUTNEURON must be a positive multiple of PO");
    end
    if (RD_LAT < 1) begin : g_err_rd_lat
        $error("RD_LAT must be at least 1");
    end
    if (FC_INNEURON_ADDR_WIDTH < clog2(INNEURON)) begin : g_err_in_aw
        $error("FC_INNEURON_ADDR_WIDTH too narrow for INNEURON");
    end
    if (FC_WEIGHT_ADDR_WIDTH < clog2(NGRP * NBEAT)) begin : g_err_w_aw
        $error("FC_WEIGHT_ADDR_WIDTH too narrow for NGRP*NBEAT");
    end
    if (FC_OUTNEURON_ADDR_WIDTH < clog2(NGRP)) begin : g_err_out_aw
        $error("FC_OUTNEURON_ADDR_WIDTH too narrow for NGRP");
    end

    fc_state_e     state, state_next;
    logic [KW-1:0] k, k_next;
    logic [GW-1:0] grp, grp_next;
    logic [DW-1:0] drain_cnt, drain_next;
    logic          stall;
    logic          issue;
    logic          issue_first;
    logic          wren_c;
    logic          done_c;
    logic          dly_valid;
    logic          dly_first;

    // Hold never blocks acceptance of start while idle.
`ifdef FC_HOLD_EN
    assign stall = hold & (state != IDLE);
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            k         <= '0;
            grp       <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            k         <= k_next;
            grp       <= grp_next;
            drain_cnt <= drain_next;
        end
    end

    always_comb begin
        state_next = state;
        k_next     = k;
        grp_next   = grp;
        drain_next = drain_cnt;
        issue      = 1'b0;
        wren_c     = 1'b0;
        done_c     = 1'b0;
        if (!stall) begin
            unique case (state)
                IDLE: begin
                    if (bus.start) state_next = RUN;
                end
                RUN: begin
                    issue = 1'b1;
                    if (k == K_LAST) begin
                        k_next     = '0;
                        drain_next = '0;
                        state_next = DRAIN;
                    end else begin
                        k_next = k + KW'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == D_LAST) begin
                        drain_next = '0;
                        state_next = WRITE;
                    end else begin
                        drain_next = drain_cnt + DW'(1);
                    end
                end
                WRITE: begin
                    wren_c = 1'b1;
                    if (grp == G_LAST) begin
                        state_next = DONE;
                    end else begin
                        grp_next   = grp + GW'(1);
                        state_next = RUN;
                    end
                end
                DONE: begin
                    done_c     = 1'b1;
                    grp_next   = '0;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign issue_first = issue & (k == '0);

    fc_valid_delay #(.DEPTH(RD_LAT)) u_delay (
        .clock     (clock),
        .reset     (reset),
        .freeze    (stall),
        .in_valid  (issue),
        .in_first  (issue_first),
        .out_valid (dly_valid),
        .out_first (dly_first)
    );

    // Addresses read as zero outside an issue beat so idle outputs stay quiet.
    assign bus.busy             = (state != IDLE);
    assign bus.done             = done_c;
    assign bus.in_neuron_rden   = issue;
    assign bus.fc_weight_rden   = issue;
    assign bus.in_neuron_addr_a = issue ? FC_INNEURON_ADDR_WIDTH'({k, 1'b0}) : '0;
    assign bus.in_neuron_addr_b = issue ? FC_INNEURON_ADDR_WIDTH'({k, 1'b1}) : '0;
    assign bus.fc_weight_addr   = issue ? (FC_WEIGHT_ADDR_WIDTH'(grp) * FC_WEIGHT_ADDR_WIDTH'(NBEAT)
                                           + FC_WEIGHT_ADDR_WIDTH'(k)) : '0;
    assign bus.enable_mult      = dly_valid & ~stall;
    assign bus.accum_sload      = dly_first & ~stall;
    assign bus.out_wren         = wren_c;
    assign bus.out_addr         = FC_OUTNEURON_ADDR_WIDTH'(grp);
    assign state_dbg            = state;
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Bench for fc_layer_sequencer: directed passes on two geometries, events
// checked by a scoreboard fed with hand-derived timelines.
module tb_fc_layer_sequencer;
    import fc_pkg::*;

    localparam int W = 38;

    logic      clock = 1'b0;
    logic      reset;
    int        cyc = 0;
    int        t0 = 0;
    int        t1 = 0;
    int        n_checks = 0;
    int        n_errors = 0;
    fc_state_e st0, st1;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_q1[$];
    logic [W-1:0] act0, req0, act1, req1;
`ifdef FC_HOLD_EN
    logic      hold = 1'b0;
`endif

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    fc_layer_sequencer_if #(.IAW(6), .WAW(8), .OAW(4)) bus0 ();
    fc_layer_sequencer_if #(.IAW(6), .WAW(8), .OAW(4)) bus1 ();

    fc_layer_sequencer #(
        .INNEURON(8), .OUTNEURON(8), .PO(4), .RD_LAT(2),
        .FC_INNEURON_ADDR_WIDTH(6), .FC_WEIGHT_ADDR_WIDTH(8), .FC_OUTNEURON_ADDR_WIDTH(4)
    ) u_dut0 (
        .clock     (clock),
        .reset     (reset),
`ifdef FC_HOLD_EN
        .hold      (hold),
`endif
        .bus       (bus0),
        .state_dbg (st0)
    );

    fc_layer_sequencer #(
        .INNEURON(2), .OUTNEURON(8), .PO(4), .RD_LAT(1),
        .FC_INNEURON_ADDR_WIDTH(6), .FC_WEIGHT_ADDR_WIDTH(8), .FC_OUTNEURON_ADDR_WIDTH(4)
    ) u_dut1 (
        .clock     (clock),
        .reset     (reset),
`ifdef FC_HOLD_EN
        .hold      (1'b0),
`endif
        .bus       (bus1),
        .state_dbg (st1)
    );

    // Event record; addresses are only meaningful alongside their strobe.
    function automatic logic [W-1:0] rec(input int rel, input logic rd, input logic wrd,
                                         input int a, input int b, input int w,
                                         input logic sl, input logic en, input logic wr,
                                         input int oa, input logic dn);
        logic [5:0] ma, mb;
        logic [7:0] mw;
        logic [3:0] mo;
        ma = rd ? 6'(a) : 6'd0;
        mb = rd ? 6'(b) : 6'd0;
        mw = wrd ? 8'(w) : 8'd0;
        mo = wr ? 4'(oa) : 4'd0;
        return {8'(rel), rd, wrd, ma, mb, mw, sl, en, wr, mo, dn};
    endfunction

    function automatic logic [W-1:0] row(input int rel, input logic rd, input int k, input int g,
                                         input int nb, input logic sl, input logic en,
                                         input logic wr, input logic dn);
        return rec(rel, rd, rd, 2 * k, 2 * k + 1, g * nb + k, sl, en, wr, g, dn);
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (bus0.in_neuron_rden || bus0.fc_weight_rden || bus0.enable_mult ||
            bus0.accum_sload || bus0.out_wren || bus0.done) begin
            act0 = rec(cyc - t0, bus0.in_neuron_rden, bus0.fc_weight_rden,
                       int'(bus0.in_neuron_addr_a), int'(bus0.in_neuron_addr_b),
                       int'(bus0.fc_weight_addr), bus0.accum_sload, bus0.enable_mult,
                       bus0.out_wren, int'(bus0.out_addr), bus0.done);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL dut0 unexpected event: got %h required none", act0);
            end else begin
                req0 = exp_q.pop_front();
                if (act0 !== req0) begin
                    n_errors++;
                    $display("FAIL dut0 event: got %h required %h", act0, req0);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (bus1.in_neuron_rden || bus1.fc_weight_rden || bus1.enable_mult ||
            bus1.accum_sload || bus1.out_wren || bus1.done) begin
            act1 = rec(cyc - t1, bus1.in_neuron_rden, bus1.fc_weight_rden,
                       int'(bus1.in_neuron_addr_a), int'(bus1.in_neuron_addr_b),
                       int'(bus1.fc_weight_addr), bus1.accum_sload, bus1.enable_mult,
                       bus1.out_wren, int'(bus1.out_addr), bus1.done);
            n_checks++;
            if (exp_q1.size() == 0) begin
                n_errors++;
                $display("FAIL dut1 unexpected event: got %h required none", act1);
            end else begin
                req1 = exp_q1.pop_front();
                if (act1 !== req1) begin
                    n_errors++;
                    $display("FAIL dut1 event: got %h required %h", act1, req1);
                end
            end
        end
    end

    // Nominal 8-in/8-out pass, RD_LAT=2: 7-cycle groups, done at +15.
    task automatic push_pass(input int off);
        int b;
        for (int g = 0; g < 2; g++) begin
            b = off + 7 * g;
            exp_q.push_back(row(b + 1, 1, 0, g, 4, 0, 0, 0, 0));
            exp_q.push_back(row(b + 2, 1, 1, g, 4, 0, 0, 0, 0));
            exp_q.push_back(row(b + 3, 1, 2, g, 4, 1, 1, 0, 0));
            exp_q.push_back(row(b + 4, 1, 3, g, 4, 0, 1, 0, 0));
            exp_q.push_back(row(b + 5, 0, 0, g, 4, 0, 1, 0, 0));
            exp_q.push_back(row(b + 6, 0, 0, g, 4, 0, 1, 0, 0));
            exp_q.push_back(row(b + 7, 0, 0, g, 4, 0, 0, 1, 0));
        end
        exp_q.push_back(row(off + 15, 0, 0, 0, 4, 0, 0, 0, 1));
    endtask

    task automatic run_clean_pass(input string tag);
        push_pass(0);
        tick();
        t0 = cyc;
        check({tag, " busy before start"}, int'(bus0.busy), 0);
        bus0.start = 1'b1;
        for (int rel = 1; rel <= 17; rel++) begin
            tick();
            bus0.start = 1'b0;
            if (rel == 1)  check({tag, " busy rel1"}, int'(bus0.busy), 1);
            if (rel == 15) check({tag, " busy rel15"}, int'(bus0.busy), 1);
            if (rel == 16) check({tag, " busy rel16"}, int'(bus0.busy), 0);
        end
        check({tag, " queue drained"}, exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        repeat (3) tick();
        check("reset state dut0", int'(st0), int'(IDLE));
        check("reset outputs dut0", int'({bus0.busy, bus0.done, bus0.in_neuron_rden,
              bus0.fc_weight_rden, bus0.accum_sload, bus0.enable_mult, bus0.out_wren}), 0);
        check("reset addr dut0", int'({bus0.in_neuron_addr_a, bus0.in_neuron_addr_b,
              bus0.fc_weight_addr, bus0.out_addr}), 0);
        reset = 1'b0;
        tick();

        run_clean_pass("pass1");

        // Stray starts at rel 2 and 10 are ignored; start at rel 16 begins a back-to-back pass.
        push_pass(0);
        push_pass(16);
        tick();
        t0 = cyc;
        bus0.start = 1'b1;
        for (int rel = 1; rel <= 33; rel++) begin
            tick();
            bus0.start = (rel == 2 || rel == 10 || rel == 16);
            if (rel == 16) check("b2b busy rel16", int'(bus0.busy), 0);
            if (rel == 17) check("b2b busy rel17", int'(bus0.busy), 1);
            if (rel == 32) check("b2b busy rel32", int'(bus0.busy), 0);
        end
        bus0.start = 1'b0;
        check("b2b queue drained", exp_q.size(), 0);

        // Reset asserted in rel 5 aborts the pass.
        exp_q.push_back(row(1, 1, 0, 0, 4, 0, 0, 0, 0));
        exp_q.push_back(row(2, 1, 1, 0, 4, 0, 0, 0, 0));
        exp_q.push_back(row(3, 1, 2, 0, 4, 1, 1, 0, 0));
        exp_q.push_back(row(4, 1, 3, 0, 4, 0, 1, 0, 0));
        exp_q.push_back(row(5, 0, 0, 0, 4, 0, 1, 0, 0));
        tick();
        t0 = cyc;
        bus0.start = 1'b1;
        for (int rel = 1; rel <= 20; rel++) begin
            tick();
            bus0.start = 1'b0;
            reset = (rel == 5);
            if (rel == 6) begin
                check("abort outputs", int'({bus0.busy, bus0.done, bus0.in_neuron_rden,
                      bus0.fc_weight_rden, bus0.accum_sload, bus0.enable_mult, bus0.out_wren}), 0);
                check("abort state", int'(st0), int'(IDLE));
            end
        end
        check("abort queue drained", exp_q.size(), 0);
        run_clean_pass("post-reset");

        // Single-beat geometry: 3-cycle groups, sload and enable together.
        exp_q1.push_back(row(1, 1, 0, 0, 1, 0, 0, 0, 0));
        exp_q1.push_back(row(2, 0, 0, 0, 1, 1, 1, 0, 0));
        exp_q1.push_back(row(3, 0, 0, 0, 1, 0, 0, 1, 0));
        exp_q1.push_back(row(4, 1, 0, 1, 1, 0, 0, 0, 0));
        exp_q1.push_back(row(5, 0, 0, 1, 1, 1, 1, 0, 0));
        exp_q1.push_back(row(6, 0, 0, 1, 1, 0, 0, 1, 0));
        exp_q1.push_back(row(7, 0, 0, 0, 1, 0, 0, 0, 1));
        tick();
        t1 = cyc;
        bus1.start = 1'b1;
        for (int rel = 1; rel <= 10; rel++) begin
            tick();
            bus1.start = 1'b0;
            if (rel == 7) check("nbeat1 busy rel7", int'(bus1.busy), 1);
            if (rel == 8) check("nbeat1 busy rel8", int'(bus1.busy), 0);
        end
        check("nbeat1 queue drained", exp_q1.size(), 0);

`ifdef FC_HOLD_EN
        // Hold during rel 3..5 shifts everything after it by three cycles.
        exp_q.push_back(row(1, 1, 0, 0, 4, 0, 0, 0, 0));
        exp_q.push_back(row(2, 1, 1, 0, 4, 0, 0, 0, 0));
        exp_q.push_back(row(6, 1, 2, 0, 4, 1, 1, 0, 0));
        exp_q.push_back(row(7, 1, 3, 0, 4, 0, 1, 0, 0));
        exp_q.push_back(row(8, 0, 0, 0, 4, 0, 1, 0, 0));
        exp_q.push_back(row(9, 0, 0, 0, 4, 0, 1, 0, 0));
        exp_q.push_back(row(10, 0, 0, 0, 4, 0, 0, 1, 0));
        exp_q.push_back(row(11, 1, 0, 1, 4, 0, 0, 0, 0));
        exp_q.push_back(row(12, 1, 1, 1, 4, 0, 0, 0, 0));
        exp_q.push_back(row(13, 1, 2, 1, 4, 1, 1, 0, 0));
        exp_q.push_back(row(14, 1, 3, 1, 4, 0, 1, 0, 0));
        exp_q.push_back(row(15, 0, 0, 1, 4, 0, 1, 0, 0));
        exp_q.push_back(row(16, 0, 0, 1, 4, 0, 1, 0, 0));
        exp_q.push_back(row(17, 0, 0, 1, 4, 0, 0, 1, 0));
        exp_q.push_back(row(18, 0, 0, 0, 4, 0, 0, 0, 1));
        tick();
        t0 = cyc;
        bus0.start = 1'b1;
        for (int rel = 1; rel <= 21; rel++) begin
            tick();
            bus0.start = 1'b0;
            hold = (rel >= 3 && rel <= 5);
            if (rel == 4)  check("hold busy rel4", int'(bus0.busy), 1);
            if (rel == 19) check("hold busy rel19", int'(bus0.busy), 0);
        end
        hold = 1'b0;
        check("hold queue drained", exp_q.size(), 0);
`endif

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
